ball_track_filter: RTL and testbench



---
 rtl/ball_track_filter.sv | 222 ++++++++++++++++++++++
 tb/tb_ball_track_filter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/ball_track_filter.sv
// Smooths the red-ball detector's per-frame centroid over a short moving window.
// It also flags when the window is full and emits one-cycle motion pulses when the average moves enough.
module ball_track_filter #(
    parameter int LOG2_DEPTH  = 2,
    parameter int MOVE_THRESH = 8,
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480
) (
    input  logic       iVgaClk,
    input  logic       reset_n,
    input  logic       iVgaVRequest,
    input  logic       iEnable,
    input  logic [8:0] iRedPixelHIndex,
    input  logic [9:0] iRedPixelVIndex,
    output logic [8:0] oRow,
    output logic [9:0] oCol,
    output logic       oValid,
    output logic       oFrameTick,
    output logic       oMoveLeft,
    output logic       oMoveRight,
    output logic       oMoveUp,
    output logic       oMoveDown
);

    localparam int DEPTH = 1 << LOG2_DEPTH;
    localparam int RW    = 9 + LOG2_DEPTH;
    localparam int CW    = 10 + LOG2_DEPTH;
    localparam int NW    = LOG2_DEPTH + 1;
    localparam int PW    = LOG2_DEPTH;
    localparam logic [NW-1:0]     FULL  = NW'(DEPTH);
    localparam logic [9:0]        V_LIM = 10'(V_ACTIVE);
    localparam logic [10:0]       H_LIM = 11'(H_ACTIVE);
    localparam logic signed [9:0]  THR_R = 10'(MOVE_THRESH);
    localparam logic signed [10:0] THR_C = 11'(MOVE_THRESH);

    logic                     vreq_q, vreq_d;
    logic                     s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
    logic [8:0]               smp_row_q, smp_row_d;
    logic [9:0]               smp_col_q, smp_col_d;
    logic                     smp_ok_q, smp_ok_d;
    logic [RW-1:0]            row_sum_q, row_sum_d;
    logic [CW-1:0]            col_sum_q, col_sum_d;
    logic [NW-1:0]            cnt_q, cnt_d;
    logic [PW-1:0]            ptr_q, ptr_d;
    logic [DEPTH-1:0][8:0]    row_buf_q, row_buf_d;
    logic [DEPTH-1:0][9:0]    col_buf_q, col_buf_d;
    logic [8:0]               avg_row_q, avg_row_d, prev_row_q, prev_row_d;
    logic [9:0]               avg_col_q, avg_col_d, prev_col_q, prev_col_d;
    logic                     prev_ok_q, prev_ok_d;
    logic                     valid_q, valid_d, tick_q, tick_d;
    logic                     left_q, left_d, right_q, right_d, up_q, up_d, down_q, down_d;
    logic                     fe_s;
    logic [8:0]               old_row_s;
    logic [9:0]               old_col_s;
    logic signed [9:0]        d_row_s;
    logic signed [10:0]       d_col_s;

    assign fe_s    = vreq_q & ~iVgaVRequest;
    assign d_row_s = {1'b0, avg_row_q} - {1'b0, prev_row_q};
    assign d_col_s = {1'b0, avg_col_q} - {1'b0, prev_col_q};

    // Next-state for the capture / accumulate / average / motion pipeline.
    always_comb begin
        vreq_d    = iVgaVRequest;
        s1_d      = fe_s & iEnable;
        s2_d      = 1'b0;
        s3_d      = s2_q;
        tick_d    = fe_s & iEnable;
        smp_row_d = smp_row_q;
        smp_col_d = smp_col_q;
        smp_ok_d  = smp_ok_q;
        row_sum_d = row_sum_q;
        col_sum_d = col_sum_q;
        cnt_d     = cnt_q;
        ptr_d     = ptr_q;
        row_buf_d = row_buf_q;
        col_buf_d = col_buf_q;
        avg_row_d = avg_row_q;
        avg_col_d = avg_col_q;
        prev_row_d = prev_row_q;
        prev_col_d = prev_col_q;
        prev_ok_d = prev_ok_q;
        valid_d   = valid_q;
        old_row_s = 9'd0;
        old_col_s = 10'd0;
        left_d    = 1'b0;
        right_d   = 1'b0;
        up_d      = 1'b0;
        down_d    = 1'b0;

        if (fe_s && iEnable) begin
            smp_row_d = iRedPixelHIndex;
            smp_col_d = iRedPixelVIndex;
            smp_ok_d  = ({1'b0, iRedPixelHIndex} < V_LIM) && ({1'b0, iRedPixelVIndex} < H_LIM);
        end else begin
            smp_ok_d  = smp_ok_q;
        end

        if (s1_q) begin
            if (smp_ok_q) begin
                // Once the window is full, the slot about to be overwritten is the oldest sample.
                if (cnt_q == FULL) begin
                    old_row_s = row_buf_q[ptr_q];
                    old_col_s = col_buf_q[ptr_q];
                end else begin
                    old_row_s = 9'd0;
                    old_col_s = 10'd0;
                end
                row_buf_d[ptr_q] = smp_row_q;
                col_buf_d[ptr_q] = smp_col_q;
                row_sum_d = row_sum_q + RW'(smp_row_q) - RW'(old_row_s);
                col_sum_d = col_sum_q + CW'(smp_col_q) - CW'(old_col_s);
                ptr_d     = ptr_q + PW'(1);
                cnt_d     = (cnt_q == FULL) ? cnt_q : cnt_q + NW'(1);
                s2_d      = 1'b1;
            end else begin
                row_sum_d = {RW{1'b0}};
                col_sum_d = {CW{1'b0}};
                cnt_d     = {NW{1'b0}};
                ptr_d     = {PW{1'b0}};
                valid_d   = 1'b0;
                s2_d      = 1'b0;
            end
        end else begin
            s2_d = 1'b0;
        end

        if (s2_q) begin
            // The previous average only counts for motion if it was itself valid.
            if (cnt_q == FULL) begin
                avg_row_d  = row_sum_q[RW-1:LOG2_DEPTH];
                avg_col_d  = col_sum_q[CW-1:LOG2_DEPTH];
                prev_row_d = avg_row_q;
                prev_col_d = avg_col_q;
                prev_ok_d  = valid_q;
                valid_d    = 1'b1;
            end else begin
                prev_ok_d  = 1'b0;
                valid_d    = 1'b0;
            end
        end else begin
            prev_ok_d = prev_ok_q;
        end

        if (s3_q && valid_q && prev_ok_q) begin
            right_d = (d_col_s >= THR_C);
            left_d  = (d_col_s <= -THR_C);
            down_d  = (d_row_s >= THR_R);
            up_d    = (d_row_s <= -THR_R);
        end else begin
            right_d = 1'b0;
            left_d  = 1'b0;
            down_d  = 1'b0;
            up_d    = 1'b0;
        end
    end

    // State registers; reset clears every pipeline stage so no pulse can leak out.
    always_ff @(posedge iVgaClk or negedge reset_n) begin
        if (!reset_n) begin
            vreq_q     <= 1'b0;
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            s3_q       <= 1'b0;
            smp_row_q  <= 9'd0;
            smp_col_q  <= 10'd0;
            smp_ok_q   <= 1'b0;
            row_sum_q  <= {RW{1'b0}};
            col_sum_q  <= {CW{1'b0}};
            cnt_q      <= {NW{1'b0}};
            ptr_q      <= {PW{1'b0}};
            row_buf_q  <= {(DEPTH*9){1'b0}};
            col_buf_q  <= {(DEPTH*10){1'b0}};
            avg_row_q  <= 9'd0;
            avg_col_q  <= 10'd0;
            prev_row_q <= 9'd0;
            prev_col_q <= 10'd0;
            prev_ok_q  <= 1'b0;
            valid_q    <= 1'b0;
            tick_q     <= 1'b0;
            left_q     <= 1'b0;
            right_q    <= 1'b0;
            up_q       <= 1'b0;
            down_q     <= 1'b0;
        end else begin
            vreq_q     <= vreq_d;
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            s3_q       <= s3_d;
            smp_row_q  <= smp_row_d;
            smp_col_q  <= smp_col_d;
            smp_ok_q   <= smp_ok_d;
            row_sum_q  <= row_sum_d;
            col_sum_q  <= col_sum_d;
            cnt_q      <= cnt_d;
            ptr_q      <= ptr_d;
            row_buf_q  <= row_buf_d;
            col_buf_q  <= col_buf_d;
            avg_row_q  <= avg_row_d;
            avg_col_q  <= avg_col_d;
            prev_row_q <= prev_row_d;
            prev_col_q <= prev_col_d;
            prev_ok_q  <= prev_ok_d;
            valid_q    <= valid_d;
            tick_q     <= tick_d;
            left_q     <= left_d;
            right_q    <= right_d;
            up_q       <= up_d;
            down_q     <= down_d;
        end
    end

    assign oRow       = avg_row_q;
    assign oCol       = avg_col_q;
    assign oValid     = valid_q;
    assign oFrameTick = tick_q;
    assign oMoveLeft  = left_q;
    assign oMoveRight = right_q;
    assign oMoveUp    = up_q;
    assign oMoveDown  = down_q;

endmodule

// File: tb/tb_ball_track_filter.sv
// Bench for ball_track_filter: directed frames followed by random frames.
// Expected outputs come from a queue-based moving-average reference model.
module tb_ball_track_filter;

    localparam int V_ACT = 480;
    localparam int H_ACT = 640;
    localparam int THR   = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       vreq;
    logic       en;
    logic [8:0] row_in;
    logic [9:0] col_in;
    logic [8:0] o_row;
    logic [9:0] o_col;
    logic       o_valid, o_tick, o_left, o_right, o_up, o_down;
    logic [24:0] obs_s;

    int errors = 0;
    int checks = 0;

    int          q_row[$];
    int          q_col[$];
    logic [8:0]  mo_row;
    logic [9:0]  mo_col;
    logic        mo_valid;

    ball_track_filter dut (
        .iVgaClk(clk), .reset_n(rst_n), .iVgaVRequest(vreq), .iEnable(en),
        .iRedPixelHIndex(row_in), .iRedPixelVIndex(col_in),
        .oRow(o_row), .oCol(o_col), .oValid(o_valid), .oFrameTick(o_tick),
        .oMoveLeft(o_left), .oMoveRight(o_right), .oMoveUp(o_up), .oMoveDown(o_down)
    );

    always #5 clk = ~clk;

    assign obs_s = {o_row, o_col, o_valid, o_tick, o_left, o_right, o_up, o_down};

    function automatic logic [24:0] pk(input logic [8:0] r, input logic [9:0] c,
                                       input logic v, input logic t, input logic [3:0] mv);
        return {r, c, v, t, mv};
    endfunction

    task automatic check_eq(input string tag, input logic [24:0] obs, input logic [24:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got row=%0d col=%0d valid=%b tick=%b LRUD=%b, expected row=%0d col=%0d valid=%b tick=%b LRUD=%b",
                     tag, obs[24:16], obs[15:6], obs[5], obs[4], obs[3:0],
                     exp[24:16], exp[15:6], exp[5], exp[4], exp[3:0]);
        end
    endtask

    task automatic model_clear();
        q_row.delete();
        q_col.delete();
        mo_row   = 9'd0;
        mo_col   = 10'd0;
        mo_valid = 1'b0;
    endtask

    // One frame: predict T+1..T+5 from the model, then drive a frame end and compare.
    task automatic frame(input logic [8:0] r, input logic [9:0] c, input logic e_en, input string tag);
        logic [24:0] e [1:5];
        logic [24:0] base;
        logic [3:0]  mv;
        int sr, sc, ar, ac, dr, dc;
        base = pk(mo_row, mo_col, mo_valid, 1'b0, 4'b0000);
        e[1] = pk(mo_row, mo_col, mo_valid, e_en, 4'b0000);
        for (int k = 2; k <= 5; k++) e[k] = base;
        if (e_en) begin
            if (int'(r) < V_ACT && int'(c) < H_ACT) begin
                q_row.push_back(int'(r));
                q_col.push_back(int'(c));
                if (q_row.size() > 4) begin
                    void'(q_row.pop_front());
                    void'(q_col.pop_front());
                end
                if (q_row.size() == 4) begin
                    sr = 0;
                    sc = 0;
                    foreach (q_row[i]) sr += q_row[i];
                    foreach (q_col[i]) sc += q_col[i];
                    ar = sr / 4;
                    ac = sc / 4;
                    mv = 4'b0000;
                    if (mo_valid) begin
                        dr = ar - int'(mo_row);
                        dc = ac - int'(mo_col);
                        mv = {dc <= -THR, dc >= THR, dr <= -THR, dr >= THR};
                    end
                    mo_row   = 9'(ar);
                    mo_col   = 10'(ac);
                    mo_valid = 1'b1;
                    e[3] = pk(mo_row, mo_col, 1'b1, 1'b0, 4'b0000);
                    e[4] = pk(mo_row, mo_col, 1'b1, 1'b0, mv);
                    e[5] = e[3];
                end else begin
                    mo_valid = 1'b0;
                    for (int k = 3; k <= 5; k++) e[k] = pk(mo_row, mo_col, 1'b0, 1'b0, 4'b0000);
                end
            end else begin
                q_row.delete();
                q_col.delete();
                mo_valid = 1'b0;
                for (int k = 2; k <= 5; k++) e[k] = pk(mo_row, mo_col, 1'b0, 1'b0, 4'b0000);
            end
        end
        row_in = r;
        col_in = c;
        en     = e_en;
        vreq   = 1'b1;
        repeat (2 + $urandom_range(0, 3)) @(posedge clk);
        #1 vreq = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk);
            #1;
            check_eq($sformatf("%s T+%0d", tag, k), obs_s, e[k]);
            if (k == 1) begin
                row_in = 9'($urandom);
                col_in = 10'($urandom);
            end
        end
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
    endtask

    task automatic mid_reset();
        row_in = 9'd50;
        col_in = 10'd60;
        en     = 1'b1;
        vreq   = 1'b1;
        repeat (3) @(posedge clk);
        #1 vreq = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_eq("reset async", obs_s, 25'd0);
        repeat (3) @(posedge clk);
        #1 check_eq("reset held", obs_s, 25'd0);
        rst_n = 1'b1;
        model_clear();
    endtask

    initial begin
        logic [8:0] rr;
        logic [9:0] cc;
        logic       ee;
        int         sel;
        rst_n  = 1'b0;
        vreq   = 1'b0;
        en     = 1'b1;
        row_in = 9'd0;
        col_in = 10'd0;
        model_clear();
        repeat (3) @(posedge clk);
        #1 check_eq("reset", obs_s, 25'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 4; i++) frame(9'd100, 10'd200, 1'b1, "const");
        frame(9'd0, 10'd700, 1'b1, "flush");
        for (int i = 0; i < 3; i++) frame(9'd0, 10'd1, 1'b1, "trunc");
        frame(9'd0, 10'd2, 1'b1, "trunc");
        frame(9'd0, 10'd700, 1'b1, "flush");
        for (int i = 0; i < 4; i++) frame(9'd100, 10'd200, 1'b1, "fill");
        frame(9'd100, 10'd240, 1'b1, "right1");
        frame(9'd100, 10'd240, 1'b1, "right2");
        frame(9'd0, 10'd700, 1'b1, "flush");
        for (int i = 0; i < 5; i++) frame(9'd100, 10'(200 + 4 * i), 1'b1, "ramp");
        frame(9'd100, 10'd700, 1'b1, "badcol");
        for (int i = 0; i < 4; i++) frame(9'd100, 10'd200, 1'b1, "refill");
        frame(9'd300, 10'd400, 1'b0, "en_low");
        frame(9'd300, 10'd400, 1'b0, "en_low");
        for (int i = 0; i < 4; i++) frame(9'd479, 10'd639, 1'b1, "edge_ok");
        frame(9'd100, 10'd640, 1'b1, "col_bound");
        for (int i = 0; i < 4; i++) frame(9'd100, 10'd100, 1'b1, "vert");
        frame(9'd140, 10'd100, 1'b1, "down");
        frame(9'd20, 10'd100, 1'b1, "up_left");
        frame(9'd480, 10'd100, 1'b1, "row_bound");
        for (int i = 0; i < 2; i++) frame(9'd200, 10'd300, 1'b1, "pre_rst");
        mid_reset();
        for (int i = 0; i < 4; i++) frame(9'd200, 10'd300, 1'b1, "post_rst");

        for (int i = 0; i < 200; i++) begin
            sel = $urandom_range(0, 19);
            rr  = 9'($urandom_range(0, V_ACT - 1));
            cc  = 10'($urandom_range(0, H_ACT - 1));
            ee  = 1'b1;
            if (sel == 0) rr = 9'($urandom_range(V_ACT, 511));
            else if (sel == 1) cc = 10'($urandom_range(H_ACT, 1023));
            else if (sel == 2) ee = 1'b0;
            frame(rr, cc, ee, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
